// File: rtl/exec_sequencer_pkg.sv
// Shared core types: data word, ALU function select and the sequencer state enum.
package exec_sequencer_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [3:0] {
      ALU_NOP  = 4'd0,
      ALU_ADD  = 4'd1,
      ALU_SUB  = 4'd2,
      ALU_AND  = 4'd3,
      ALU_OR   = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SLT  = 4'd6,
      ALU_SLTU = 4'd7,
      ALU_SLL  = 4'd8,
      ALU_SRL  = 4'd9,
      ALU_SRA  = 4'd10
   } ALU_f;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } seq_state_t;

   function automatic logic is_shift(input ALU_f f);
      return (f == ALU_SLL) || (f == ALU_SRL) || (f == ALU_SRA);
   endfunction

endpackage

// File: rtl/exec_sequencer_alu.sv
// Single-cycle combinational ALU. SUB computes b - a; compares are zero-extended flags.
module exec_sequencer_alu
   import exec_sequencer_pkg::*;
(
   input  ALU_f  func,
   input  word_t a,
   input  word_t b,
   output word_t y
);

   always_comb begin
      y = a;
      case (func)
         ALU_NOP:  y = a;
         ALU_ADD:  y = a + b;
         ALU_SUB:  y = b - a;
         ALU_AND:  y = a & b;
         ALU_OR:   y = a | b;
         ALU_XOR:  y = a ^ b;
         ALU_SLT:  y = {31'b0, $signed(a) < $signed(b)};
         ALU_SLTU: y = {31'b0, a < b};
         ALU_SLL:  y = a << b[4:0];
         ALU_SRL:  y = a >> b[4:0];
         ALU_SRA:  y = word_t'($signed(a) >>> b[4:0]);
         default:  y = a;
      endcase
   end

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle execution sequencer: single-step ALU ops finish in one cycle,
// shifts iterate one bit per cycle through the same ALU.
module exec_sequencer
   import exec_sequencer_pkg::*;
#(
   parameter int SHAMT_W = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       kill,
   input  logic       req_valid,
   output logic       req_ready,
   input  ALU_f       req_func,
   input  word_t      req_a,
   input  word_t      req_b,
   output logic       resp_valid,
   input  logic       resp_ready,
   output word_t      resp_data,
   output logic       busy,
   output seq_state_t state
);

   // Handshake: a transfer happens on a rising edge where valid and ready are both high.
   // Upstream: req_ready is high in IDLE, or in DONE while the consumer takes the result,
   // and never while rst or kill is asserted. Downstream: resp_valid/resp_data hold in DONE
   // until resp_ready is seen high.

   logic [SHAMT_W-1:0] cnt;
   word_t              acc;
   ALU_f               func_q;
   ALU_f               alu_func;
   word_t              alu_a;
   word_t              alu_b;
   word_t              alu_y;
   logic [SHAMT_W-1:0] shamt;
   logic               accept;

   assign shamt      = req_b[SHAMT_W-1:0];
   assign req_ready  = !rst && !kill &&
                       ((state == IDLE) || ((state == DONE) && resp_ready));
   assign accept     = req_valid && req_ready;
   assign resp_valid = (state == DONE);
   assign busy       = (state != IDLE);
   assign resp_data  = acc;

   // During SHIFT the ALU sees the accumulator and a fixed one-bit amount.
   always_comb begin
      alu_func = req_func;
      alu_a    = req_a;
      alu_b    = req_b;
      if (state == SHIFT) begin
         alu_func = func_q;
         alu_a    = acc;
         alu_b    = word_t'(1);
      end
   end

   exec_sequencer_alu u_alu (
      .func (alu_func),
      .a    (alu_a),
      .b    (alu_b),
      .y    (alu_y)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         acc    <= '0;
         cnt    <= '0;
         func_q <= ALU_NOP;
      end else if (kill) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (accept) begin
                  func_q <= req_func;
                  if (is_shift(req_func) && (shamt != '0)) begin
                     acc   <= req_a;
                     cnt   <= shamt;
                     state <= SHIFT;
                  end else begin
                     acc   <= is_shift(req_func) ? req_a : alu_y;
                     state <= DONE;
                  end
               end else if ((state == DONE) && resp_ready) begin
                  state <= IDLE;
               end
            end
            SHIFT: begin
               acc <= alu_y;
               cnt <= cnt - 1'b1;
               if (cnt == SHAMT_W'(1)) begin
                  state <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: timing, results, hold, kill and reset behaviour.
module tb_exec_sequencer;
   import exec_sequencer_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       kill;
   logic       req_valid;
   logic       req_ready;
   ALU_f       req_func;
   word_t      req_a;
   word_t      req_b;
   logic       resp_valid;
   logic       resp_ready;
   word_t      resp_data;
   logic       busy;
   seq_state_t state;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] exp_q[$];

   exec_sequencer #(.SHAMT_W(5)) dut (
      .clk        (clk),
      .rst        (rst),
      .kill       (kill),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_func   (req_func),
      .req_a      (req_a),
      .req_b      (req_b),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .busy       (busy),
      .state      (state)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #200000;
      n_checks++;
      n_fail++;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input ALU_f f, input word_t a, input word_t b);
      req_valid = 1'b1;
      req_func  = f;
      req_a     = a;
      req_b     = b;
   endtask

   task automatic drop_req();
      req_valid = 1'b0;
      req_func  = ALU_NOP;
      req_a     = '0;
      req_b     = '0;
   endtask

   // scoreboard
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_resp(input string tag);
      logic [31:0] exp;
      check({tag, "_valid"}, 32'(resp_valid), 32'd1);
      if (exp_q.size() == 0) begin
         check({tag, "_queue_empty"}, 32'd1, 32'd0);
      end else begin
         exp = exp_q.pop_front();
         check({tag, "_data"}, resp_data, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_state"}, 32'(state), 32'(IDLE));
      check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   ALU_f  b2b_f[4] = '{ALU_SLT, ALU_SLTU, ALU_AND, ALU_NOP};
   word_t b2b_a[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hF0F0_1234, 32'hDEAD_BEEF};
   word_t b2b_b[4] = '{32'h0000_0001, 32'h0000_0001, 32'h0FF0_FFFF, 32'h1111_1111};
   word_t b2b_y[4] = '{32'h0000_0001, 32'h0000_0000, 32'h00F0_1234, 32'hDEAD_BEEF};

   initial begin
      rst        = 1'b1;
      kill       = 1'b0;
      resp_ready = 1'b1;
      drop_req();
      tick();
      tick();
      rst = 1'b0;
      #1;
      check_idle("reset");
      check("reset_req_ready", 32'(req_ready), 32'd1);
      check("reset_resp_data", resp_data, 32'd0);

      // SUB is b - a
      drive_req(ALU_SUB, 32'd3, 32'd10);
      #1 check("sub_req_ready", 32'(req_ready), 32'd1);
      exp_q.push_back(32'd7);
      tick();
      drop_req();
      #1 check_resp("sub");
      check("sub_busy", 32'(busy), 32'd1);
      tick();
      check_idle("sub_after");

      // SRA by 4: four SHIFT cycles, then DONE
      drive_req(ALU_SRA, 32'h8000_0000, 32'd4);
      exp_q.push_back(32'hF800_0000);
      tick();
      drop_req();
      for (int i = 0; i < 4; i++) begin
         #1;
         check("sra_busy", 32'(busy), 32'd1);
         check("sra_no_valid", 32'(resp_valid), 32'd0);
         check("sra_req_ready", 32'(req_ready), 32'd0);
         tick();
      end
      check_resp("sra");
      check("sra_busy_done", 32'(busy), 32'd1);
      tick();
      check_idle("sra_after");

      // SLL with b=33 uses only the low 5 bits: shift by 1
      drive_req(ALU_SLL, 32'd1, 32'd33);
      exp_q.push_back(32'h0000_0002);
      tick();
      drop_req();
      #1 check("sll33_shift", 32'(state), 32'(SHIFT));
      tick();
      check_resp("sll33");
      // back-to-back SLL by 0 passes a through with latency 1
      drive_req(ALU_SLL, 32'h1234_5678, 32'd0);
      #1 check("sll0_req_ready", 32'(req_ready), 32'd1);
      exp_q.push_back(32'h1234_5678);
      tick();
      drop_req();
      #1 check_resp("sll0");
      tick();
      check_idle("sll0_after");

      // consumer stalls 3 cycles in DONE with a queued ADD
      resp_ready = 1'b0;
      drive_req(ALU_XOR, 32'h0000_F0F0, 32'h0000_0FF0);
      exp_q.push_back(32'h0000_FF00);
      tick();
      drive_req(ALU_ADD, 32'd5, 32'd6);
      for (int i = 0; i < 3; i++) begin
         #1;
         check("hold_valid", 32'(resp_valid), 32'd1);
         check("hold_data", resp_data, 32'h0000_FF00);
         check("hold_req_ready", 32'(req_ready), 32'd0);
         tick();
      end
      resp_ready = 1'b1;
      #1 check_resp("xor");
      check("b2b_req_ready", 32'(req_ready), 32'd1);
      exp_q.push_back(32'd11);
      tick();
      #1 check_resp("add");

      // back-to-back single-step ops, one per cycle
      for (int i = 0; i < 4; i++) begin
         drive_req(b2b_f[i], b2b_a[i], b2b_b[i]);
         #1 check("b2b_ready", 32'(req_ready), 32'd1);
         exp_q.push_back(b2b_y[i]);
         tick();
         #1 check_resp("b2b");
      end
      drop_req();
      tick();
      check_idle("b2b_after");

      // kill two cycles into SRL while a new request is offered
      drive_req(ALU_SRL, 32'h0000_00FF, 32'd8);
      tick();
      drop_req();
      tick();
      kill = 1'b1;
      drive_req(ALU_ADD, 32'd1, 32'd2);
      #1 check("kill_req_ready", 32'(req_ready), 32'd0);
      tick();
      kill = 1'b0;
      drop_req();
      #1 check_idle("kill");
      tick();
      check_idle("kill_no_accept");

      // reset while in DONE with a stalled consumer
      resp_ready = 1'b0;
      drive_req(ALU_ADD, 32'd7, 32'd8);
      tick();
      drop_req();
      #1 check("rstdone_pre", 32'(state), 32'(DONE));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1 check_idle("rst_done");
      check("rst_done_req_ready", 32'(req_ready), 32'd1);
      check("rst_done_data", resp_data, 32'd0);

      // reset mid-SHIFT
      resp_ready = 1'b1;
      drive_req(ALU_SLL, 32'd1, 32'd10);
      tick();
      drop_req();
      tick();
      #1 check("rstshift_pre", 32'(state), 32'(SHIFT));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1 check_idle("rst_shift");
      check("rst_shift_req_ready", 32'(req_ready), 32'd1);
      check("rst_shift_data", resp_data, 32'd0);

      // final report
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/exec_sequencer.md
EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 SHALL have parameter SHAMT_W, default 5, meaning shift-amount bits taken from req_b.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port kill  input  1  synchronous abort of the in-flight operation.
REQ-005 SHALL have port req_valid  input  1  operation request present.
REQ-006 SHALL have port req_ready  output  1  request accepted this cycle when high with req_valid.
REQ-007 SHALL have port req_func  input  ALU_f  operation select.
REQ-008 SHALL have port req_a  input  word_t  operand a.
REQ-009 SHALL have port req_b  input  word_t  operand b; shift amount = req_b[SHAMT_W-1:0].
REQ-010 SHALL have port resp_valid  output  1  result available.
REQ-011 SHALL have port resp_ready  input  1  consumer takes result.
REQ-012 SHALL have port resp_data  output  word_t  result.
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE (used as stall source).

Function
REQ-014 SHALL implement states IDLE, SHIFT, DONE.
REQ-015 SHALL assert req_ready in IDLE, and in DONE only when resp_ready is high; low in SHIFT.
REQ-016 SHALL, on accept of a non-shift func (ADD, SUB, AND, OR, XOR, SLT, SLTU), compute the result in one step and enter DONE: resp_valid one cycle after accept.
REQ-017 SHALL give SUB as req_b - req_a, SLT signed compare, SLTU unsigned compare, zero-extended 1-bit compare results.
REQ-018 SHALL treat ALU_NOP as pass-through: resp_data = req_a, latency 1.
REQ-019 SHALL, on accept of SLL/SRL/SRA with amount k>0, load accumulator = req_a, counter = k, enter SHIFT.
REQ-020 SHALL, in SHIFT, shift the accumulator by exactly one bit per cycle and decrement the counter; enter DONE when the counter reaches 0: resp_valid at accept+k+1.
REQ-021 SHALL, for a shift with k=0, enter DONE directly with resp_data = req_a (latency 1).
REQ-022 SHALL make SRA replicate bit 31 on every step; SRL/SLL fill zeros.
REQ-023 SHALL ignore req_b bits above SHAMT_W-1 for shifts.
REQ-024 SHALL hold resp_valid and resp_data stable in DONE until resp_ready is high.
REQ-025 SHALL, in DONE with resp_ready and req_valid both high, retire the result and accept the new request in the same cycle (back-to-back, one non-shift op per cycle).
REQ-026 SHALL, in DONE with resp_ready high and req_valid low, return to IDLE.
REQ-027 SHALL, on kill, go to IDLE next cycle, drop any result, and not accept a request that cycle (kill beats req_valid and resp_ready).
REQ-028 SHALL drive resp_valid only in DONE; resp_data is don't-care outside DONE.

Reset
REQ-029 SHALL, on rst, enter IDLE with resp_valid=0, busy=0, req_ready=1 next cycle, counter=0, accumulator=0, resp_data=0.
REQ-030 SHALL give rst priority over kill and all handshakes, including mid-SHIFT and in DONE.

Structure
REQ-031 SHALL take ALU_f and word_t from the shared core package; add the state enum (seq_state_t) there.
REQ-032 SHALL instantiate the existing ALU module as its sole sub-module for single-step ops, feeding it operand 1 for each shift step; no barrel shifter.

Verification
REQ-033 SHALL cover: SUB a=3, b=10, resp_ready=1 -> resp_valid 1 cycle after accept, resp_data=7, then IDLE.
REQ-034 SHALL cover: SRA a=0x80000000, b=4 -> busy 5 cycles, resp_valid at accept+5, resp_data=0xF8000000.
REQ-035 SHALL cover: SLL a=1, b=33 -> shift by 1, resp_data=0x00000002 at accept+2; SLL b=0 -> resp_data=a at accept+1.
REQ-036 SHALL cover: resp_ready held low 3 cycles in DONE -> resp_data/resp_valid stable, req_ready=0; then resp_ready=1 with queued ADD 5+6 -> back-to-back accept, next resp_data=11.
REQ-037 SHALL cover: kill asserted 2 cycles into SRL a=0xFF, b=8 while req_valid=1 -> IDLE next cycle, no resp_valid, request not accepted.
REQ-038 SHALL cover: rst in DONE and mid-SHIFT -> resp_valid=0, busy=0, req_ready=1 the cycle after.
